// File: rtl/spi_master_crc_gen_if.sv
// Handshake and SPI pin bundle for spi_master_crc_gen.
// The master modport is the controller's view; slave is the host/peripheral side.
interface spi_master_crc_gen_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_SS     = 1
);
    localparam int unsigned SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

    logic                  start;
    logic [SSW-1:0]        ss_sel;
    logic [DATA_WIDTH-1:0] data_in_master;
    logic                  miso;
    logic                  sclk_m;
    logic                  mosi;
    logic [NUM_SS-1:0]     ss;
    logic                  busy;
    logic                  finish;
    logic [DATA_WIDTH-1:0] data_out_master;
    logic                  crc_err;

    modport master (
        input  start, ss_sel, data_in_master, miso,
        output sclk_m, mosi, ss, busy, finish, data_out_master, crc_err
    );

    modport slave (
        output start, ss_sel, data_in_master, miso,
        input  sclk_m, mosi, ss, busy, finish, data_out_master, crc_err
    );
endinterface

// File: rtl/spi_master_crc_gen.sv
// SPI master sending DATA_WIDTH data bits plus their CRC, receiving a payload and CRC,
// and flagging a receive CRC mismatch at the end of each frame.
module spi_master_crc_gen #(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY   = 4'b0011,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT   = '0,
    parameter int unsigned          DIV_FRE    = 10,
    parameter bit                   CPOL       = 1'b0,
    parameter bit                   CPHA       = 1'b0,
    parameter int unsigned          NUM_SS     = 1
) (
    input  logic                 clk_m,
    input  logic                 rst,
    spi_master_crc_gen_if.master bus
);
    localparam int unsigned N     = DATA_WIDTH + CRC_WIDTH;
    localparam int unsigned H     = DIV_FRE / 2;
    localparam int unsigned HW    = (H > 1) ? $clog2(H) : 1;
    localparam int unsigned EDGES = 2 * N;
    localparam int unsigned EW    = $clog2(EDGES + 1);
    localparam int unsigned BW    = $clog2(N + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_TRAIL, S_DONE} state_t;

    state_t                r_state,  w_state;
    logic [HW-1:0]         r_cnt,    w_cnt;
    logic [EW-1:0]         r_edge,   w_edge;
    logic [BW-1:0]         r_txb,    w_txb;
    logic [BW-1:0]         r_rxb,    w_rxb;
    logic [N-1:0]          r_tx_sh,  w_tx_sh;
    logic [N-1:0]          r_rx_sh,  w_rx_sh;
    logic [CRC_WIDTH-1:0]  r_tx_crc, w_tx_crc;
    logic [CRC_WIDTH-1:0]  r_rx_crc, w_rx_crc;
    logic                  r_sclk,   w_sclk;
    logic                  r_mosi,   w_mosi;
    logic [NUM_SS-1:0]     r_ss,     w_ss;
    logic                  r_busy,   w_busy;
    logic                  r_finish, w_finish;
    logic [DATA_WIDTH-1:0] r_dout,   w_dout;
    logic                  r_err,    w_err;

    logic [EW-1:0] w_edge_n;
    logic          w_tick;
    logic          w_sample;
    logic          w_advance;

    function automatic logic [CRC_WIDTH-1:0] f_crc_step(input logic [CRC_WIDTH-1:0] crc,
                                                        input logic b);
        logic fb;
        fb = crc[CRC_WIDTH-1] ^ b;
        return CRC_WIDTH'(crc << 1) ^ (fb ? CRC_POLY : '0);
    endfunction

    // Odd edges are leading edges; the phase decides which kind samples and which shifts.
    assign w_edge_n  = r_edge + EW'(1);
    assign w_tick    = (r_cnt == HW'(H - 1));
    assign w_sample  = CPHA ? ~w_edge_n[0] : w_edge_n[0];
    assign w_advance = CPHA ? (w_edge_n[0] && (w_edge_n != EW'(1)))
                            : (~w_edge_n[0] && (w_edge_n != EW'(EDGES)));

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_edge   = r_edge;
        w_txb    = r_txb;
        w_rxb    = r_rxb;
        w_tx_sh  = r_tx_sh;
        w_rx_sh  = r_rx_sh;
        w_tx_crc = r_tx_crc;
        w_rx_crc = r_rx_crc;
        w_sclk   = r_sclk;
        w_mosi   = r_mosi;
        w_ss     = r_ss;
        w_busy   = r_busy;
        w_finish = 1'b0;
        w_dout   = r_dout;
        w_err    = r_err;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start && (32'(bus.ss_sel) < NUM_SS)) begin
                    w_state  = S_SETUP;
                    w_cnt    = '0;
                    w_edge   = '0;
                    w_txb    = '0;
                    w_rxb    = '0;
                    w_tx_sh  = {bus.data_in_master, CRC_WIDTH'(0)};
                    w_tx_crc = CRC_INIT;
                    w_rx_crc = CRC_INIT;
                    w_mosi   = bus.data_in_master[DATA_WIDTH-1];
                    w_ss     = ~(NUM_SS'(1) << bus.ss_sel);
                    w_busy   = 1'b1;
                end
            end

            S_SETUP, S_XFER: begin
                w_cnt = r_cnt + HW'(1);
                if (w_tick) begin
                    w_cnt   = '0;
                    w_sclk  = ~r_sclk;
                    w_edge  = w_edge_n;
                    w_state = (w_edge_n == EW'(EDGES)) ? S_TRAIL : S_XFER;
                    if (w_sample) begin
                        w_rx_sh = {r_rx_sh[N-2:0], bus.miso};
                        w_rxb   = r_rxb + BW'(1);
                        if (r_rxb < BW'(DATA_WIDTH)) begin
                            w_rx_crc = f_crc_step(r_rx_crc, bus.miso);
                        end
                    end
                    // The CRC tracks data bits as they leave and is spliced in after the last one.
                    if (w_advance) begin
                        w_tx_sh = r_tx_sh << 1;
                        w_txb   = r_txb + BW'(1);
                        if (r_txb < BW'(DATA_WIDTH)) begin
                            w_tx_crc = f_crc_step(r_tx_crc, r_tx_sh[N-1]);
                            if (r_txb == BW'(DATA_WIDTH - 1)) begin
                                w_tx_sh[N-1 -: CRC_WIDTH] = w_tx_crc;
                            end
                        end
                        w_mosi = w_tx_sh[N-1];
                    end
                end
            end

            S_TRAIL: begin
                w_cnt = r_cnt + HW'(1);
                if (w_tick) begin
                    w_cnt    = '0;
                    w_state  = S_DONE;
                    w_finish = 1'b1;
                    w_ss     = '1;
                    w_dout   = r_rx_sh[N-1:CRC_WIDTH];
                    w_err    = (r_rx_crc != r_rx_sh[CRC_WIDTH-1:0]);
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_mosi  = 1'b0;
            end

            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_m) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_edge   <= '0;
            r_txb    <= '0;
            r_rxb    <= '0;
            r_tx_sh  <= '0;
            r_rx_sh  <= '0;
            r_tx_crc <= CRC_INIT;
            r_rx_crc <= CRC_INIT;
            r_sclk   <= CPOL;
            r_mosi   <= 1'b0;
            r_ss     <= '1;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_dout   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_edge   <= w_edge;
            r_txb    <= w_txb;
            r_rxb    <= w_rxb;
            r_tx_sh  <= w_tx_sh;
            r_rx_sh  <= w_rx_sh;
            r_tx_crc <= w_tx_crc;
            r_rx_crc <= w_rx_crc;
            r_sclk   <= w_sclk;
            r_mosi   <= w_mosi;
            r_ss     <= w_ss;
            r_busy   <= w_busy;
            r_finish <= w_finish;
            r_dout   <= w_dout;
            r_err    <= w_err;
        end
    end

    assign bus.sclk_m          = r_sclk;
    assign bus.mosi            = r_mosi;
    assign bus.ss              = r_ss;
    assign bus.busy            = r_busy;
    assign bus.finish          = r_finish;
    assign bus.data_out_master = r_dout;
    assign bus.crc_err         = r_err;
endmodule
